ip_codma_task_sched: RTL

- CPU-side task scheduler in front of ip_codma_top.
- Accepts (task_pointer, status_pointer) descriptors into a small FIFO and launches them on the CODMA one at a time.
- Sequences the CODMA start/stop/busy/irq handshake and reports per-task completion, launch errors and aborts.
- Lets software queue several transfers without polling CODMA between them.

---
 rtl/ip_codma_pkg.sv | 29 ++
 rtl/ip_codma_task_sched_if.sv | 24 ++
 rtl/ip_codma_desc_fifo.sv | 64 ++++++
 rtl/ip_codma_task_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ip_codma_pkg.sv
// ip_codma_pkg: shared types for the CODMA block and its task scheduler.
// Holds scheduler FSM states, descriptor layout and the CODMA CPU bundle.
package ip_codma_pkg;

  localparam int SCHED_START_TIMEOUT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DRAIN,
    S_STOP
  } sched_state_t;

  typedef struct packed {
    logic [31:0] task_ptr;
    logic [31:0] status_ptr;
  } task_desc_t;

  typedef struct packed {
    logic        start;
    logic        stop;
    logic [31:0] task_pointer;
    logic [31:0] status_pointer;
    logic        busy;
    logic        irq;
  } cpu_interface_t;

endpackage

// File: rtl/ip_codma_task_sched_if.sv
// ip_codma_task_sched_if: descriptor push handshake into the scheduler.
// The CPU side is the master, the scheduler FIFO is the slave.
interface ip_codma_task_sched_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_task_ptr_i;
  logic [31:0] req_status_ptr_i;

  modport master (
    output req_valid_i,
    output req_task_ptr_i,
    output req_status_ptr_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_task_ptr_i,
    input  req_status_ptr_i,
    output req_ready_o
  );

endinterface

// File: rtl/ip_codma_desc_fifo.sv
// ip_codma_desc_fifo: small synchronous FIFO of task descriptors.
// Flush dominates push/pop; level_nxt lets the parent register status.
module ip_codma_desc_fifo
  import ip_codma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  task_desc_t             wdata,
  output task_desc_t             rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_nxt,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  task_desc_t    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign rdata = mem[rptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      level <= level_nxt;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ip_codma_task_sched.sv
// ip_codma_task_sched: queues CODMA task descriptors and launches them
// one at a time through the start/busy/irq/stop handshake.
module ip_codma_task_sched
  import ip_codma_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = SCHED_START_TIMEOUT,
  parameter int CNT_W         = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  ip_codma_task_sched_if.slave   req,
  input  logic                   abort_i,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic                   sched_busy_o,
  output logic                   done_o,
  output logic [CNT_W-1:0]       done_count_o,
  output logic                   launch_err_o,
  output logic                   aborted_o,
  output logic                   dma_start_o,
  output logic                   dma_stop_o,
  output logic [31:0]            dma_task_ptr_o,
  output logic [31:0]            dma_status_ptr_o,
  input  logic                   dma_busy_i,
  input  logic                   dma_irq_i
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  sched_state_t   state_q, state_n;
  logic [TW-1:0]  tmo_q, tmo_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  task_desc_t     desc_q, desc_n, head;
  logic           start_q, start_n;
  logic           stop_q, stop_n;
  logic           done_q, done_n;
  logic           err_q, err_n;
  logic           abt_q, abt_n;
  logic           rdy_q, busy_q;
  logic           push, pop, flush;
  logic           full, empty, tmo_hit;
  logic [LW-1:0]  level_nxt;
  cpu_interface_t cpu;

  always_comb begin
    cpu.start          = start_q;
    cpu.stop           = stop_q;
    cpu.task_pointer   = desc_q.task_ptr;
    cpu.status_pointer = desc_q.status_ptr;
    cpu.busy           = dma_busy_i;
    cpu.irq            = dma_irq_i;
  end

  assign dma_start_o      = cpu.start;
  assign dma_stop_o       = cpu.stop;
  assign dma_task_ptr_o   = cpu.task_pointer;
  assign dma_status_ptr_o = cpu.status_pointer;

  assign req.req_ready_o = rdy_q;
  assign sched_busy_o    = busy_q;
  assign done_o          = done_q;
  assign done_count_o    = cnt_q;
  assign launch_err_o    = err_q;
  assign aborted_o       = abt_q;

  // a push coinciding with abort is dropped even though ready was shown
  assign push    = req.req_valid_i && rdy_q && !abort_i;
  assign tmo_hit = (tmo_q == TW'(START_TIMEOUT - 1));

  ip_codma_desc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wdata     ('{task_ptr: req.req_task_ptr_i,
                  status_ptr: req.req_status_ptr_i}),
    .rdata     (head),
    .level     (fifo_level_o),
    .level_nxt (level_nxt),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      cnt_q   <= '0;
      desc_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tmo_q   <= tmo_n;
      cnt_q   <= cnt_n;
      desc_q  <= desc_n;
      start_q <= start_n;
      stop_q  <= stop_n;
      done_q  <= done_n;
      err_q   <= err_n;
      abt_q   <= abt_n;
      rdy_q   <= (level_nxt != LW'(DEPTH)) && (state_n != S_STOP);
      busy_q  <= (state_n != S_IDLE) || (level_nxt != '0);
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE:
        if (!abort_i && !empty && !cpu.busy) state_n = S_LAUNCH;
      S_LAUNCH:
        if (abort_i)       state_n = S_STOP;
        else if (cpu.busy) state_n = S_RUN;
        else if (tmo_hit)  state_n = S_IDLE;
      S_RUN:
        if (abort_i)      state_n = S_STOP;
        else if (cpu.irq) state_n = S_DRAIN;
      S_DRAIN:
        if (abort_i)        state_n = S_STOP;
        else if (!cpu.busy) state_n = S_IDLE;
      S_STOP:
        if (!cpu.busy) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    flush   = 1'b0;
    start_n = 1'b0;
    stop_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    abt_n   = 1'b0;
    desc_n  = desc_q;
    cnt_n   = cnt_q;
    tmo_n   = tmo_q;
    unique case (state_q)
      S_IDLE:
        if (abort_i) begin
          flush = 1'b1;
          abt_n = 1'b1;
        end else if (!empty && !cpu.busy) begin
          pop     = 1'b1;
          desc_n  = head;
          start_n = 1'b1;
          tmo_n   = '0;
        end
      S_LAUNCH:
        if (abort_i) begin
          flush  = 1'b1;
          stop_n = 1'b1;
        end else if (tmo_hit && !cpu.busy) begin
          err_n = 1'b1;
        end else if (!cpu.busy) begin
          start_n = 1'b1;
          tmo_n   = tmo_q + TW'(1);
        end
      S_RUN: begin
        // irq still completes the task when abort lands on the same cycle
        if (cpu.irq) begin
          done_n = 1'b1;
          cnt_n  = cnt_q + CNT_W'(1);
        end
        if (abort_i) begin
          flush  = 1'b1;
          stop_n = 1'b1;
        end
      end
      S_DRAIN:
        if (abort_i) begin
          flush  = 1'b1;
          stop_n = 1'b1;
        end
      S_STOP:
        if (cpu.busy) stop_n = 1'b1;
        else          abt_n  = 1'b1;
      default: ;
    endcase
  end

endmodule
